// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 6-digit common-anode seven-segment display.
// Double-buffered frame input; new frames become visible only at frame boundaries or while idle.
module seg_scan_ctrl #(
   parameter int unsigned SCAN_DIV  = 50_000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [23:0] wr_data,
   input  logic [5:0]  wr_dp,
   input  logic [5:0]  wr_blank,
   output logic [5:0]  sel,
   output logic [7:0]  seg,
   output logic        frame_done
);

   localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CntW-1:0] CntLast   = CntW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

   typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;

   logic [23:0] shd_data_q, act_data_q;
   logic [5:0]  shd_dp_q, act_dp_q;
   logic [5:0]  shd_blank_q, act_blank_q;
   logic        pend_q;

   logic [5:0]  sel_q, sel_d;
   logic [7:0]  seg_q, seg_d;
   logic        frame_done_q;

   logic        slot_end, frame_end, accept, commit;
   logic [3:0]  cur_nib;
   logic        cur_dp, cur_blank;

   // Active-low gfedcba
   function automatic logic [6:0] dec7(input logic [3:0] n);
      logic [6:0] r;
      case (n)
         4'h0: r = 7'h40;
         4'h1: r = 7'h79;
         4'h2: r = 7'h24;
         4'h3: r = 7'h30;
         4'h4: r = 7'h19;
         4'h5: r = 7'h12;
         4'h6: r = 7'h02;
         4'h7: r = 7'h78;
         4'h8: r = 7'h00;
         4'h9: r = 7'h10;
         4'hA: r = 7'h08;
         4'hB: r = 7'h03;
         4'hC: r = 7'h46;
         4'hD: r = 7'h21;
         4'hE: r = 7'h06;
         default: r = 7'h0E;
      endcase
      return r;
   endfunction

   assign slot_end  = (state_q == StDrive) && (cnt_q == CntLast);
   assign frame_end = en && slot_end && (idx_q == 3'd5);
   assign wr_ready  = ~pend_q;
   assign accept    = wr_valid && !pend_q;
   // Accept and commit are mutually exclusive: one needs pend low, the other pend high
   assign commit    = pend_q && (frame_end || (state_q == StIdle));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (!en) begin
         state_d = StIdle;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            StIdle: begin
               state_d = StBlank;
               cnt_d   = '0;
               idx_d   = '0;
            end
            StBlank: begin
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == BlankLast) state_d = StDrive;
            end
            StDrive: begin
               if (slot_end) begin
                  cnt_d   = '0;
                  idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                  state_d = StBlank;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b1;
      case (idx_q)
         3'd0: begin cur_nib = act_data_q[3:0];   cur_dp = act_dp_q[0]; cur_blank = act_blank_q[0]; end
         3'd1: begin cur_nib = act_data_q[7:4];   cur_dp = act_dp_q[1]; cur_blank = act_blank_q[1]; end
         3'd2: begin cur_nib = act_data_q[11:8];  cur_dp = act_dp_q[2]; cur_blank = act_blank_q[2]; end
         3'd3: begin cur_nib = act_data_q[15:12]; cur_dp = act_dp_q[3]; cur_blank = act_blank_q[3]; end
         3'd4: begin cur_nib = act_data_q[19:16]; cur_dp = act_dp_q[4]; cur_blank = act_blank_q[4]; end
         3'd5: begin cur_nib = act_data_q[23:20]; cur_dp = act_dp_q[5]; cur_blank = act_blank_q[5]; end
         default: ;
      endcase
   end

   always_comb begin
      sel_d = 6'h3F;
      seg_d = 8'hFF;
      if (state_q == StDrive) begin
         sel_d = ~(6'b000001 << idx_q);
         if (!cur_blank) seg_d = {~cur_dp, dec7(cur_nib)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_q       <= 1'b0;
         shd_data_q   <= '0;
         shd_dp_q     <= '0;
         shd_blank_q  <= '0;
         act_data_q   <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= 6'h3F;
         sel_q        <= 6'h3F;
         seg_q        <= 8'hFF;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         sel_q        <= sel_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_end;
         if (accept) begin
            shd_data_q  <= wr_data;
            shd_dp_q    <= wr_dp;
            shd_blank_q <= wr_blank;
            pend_q      <= 1'b1;
         end else if (commit) begin
            act_data_q  <= shd_data_q;
            act_dp_q    <= shd_dp_q;
            act_blank_q <= shd_blank_q;
            pend_q      <= 1'b0;
         end
      end
   end

   assign sel        = sel_q;
   assign seg        = seg_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a short scan period (SCAN_DIV=10, BLANK_CYC=2).
// Outputs are sampled 1 time unit after each rising edge.
module tb_seg_scan_ctrl;

   localparam int unsigned SCAN_DIV  = 10;
   localparam int unsigned BLANK_CYC = 2;

   logic        clk = 1'b0;
   logic        rst, en, wr_valid, wr_ready, frame_done;
   logic [23:0] wr_data;
   logic [5:0]  wr_dp, wr_blank, sel;
   logic [7:0]  seg;

   int n_cmp = 0;
   int n_bad = 0;

   // Active-low select per digit while driving
   logic [5:0] sel_on [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
   // 24'h123456, no dp, none blanked
   logic [7:0] seg_a  [6] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
   // 24'hABCDEF, no dp, none blanked
   logic [7:0] seg_b  [6] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88};
   // 24'h7890CB, dp on digit2, digit5 blanked
   logic [7:0] seg_c  [6] = '{8'h83, 8'hC6, 8'h40, 8'h90, 8'h80, 8'hFF};

   seg_scan_ctrl #(
      .SCAN_DIV (SCAN_DIV),
      .BLANK_CYC(BLANK_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .wr_dp     (wr_dp),
      .wr_blank  (wr_blank),
      .sel       (sel),
      .seg       (seg),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Writes are always single-cycle offers
   task automatic step();
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".sel"}, sel, 6'h3F);
      chk({tag, ".seg"}, seg, 8'hFF);
      chk({tag, ".wr_ready"}, wr_ready, 1'b1);
      chk({tag, ".frame_done"}, frame_done, 1'b0);
   endtask

   // Steps through digit slot s; after step c the outputs show slot s, count c.
   // wr_at: count at whose edge wr_valid is offered (-1 = none).
   task automatic slot(input int s, input logic [7:0] seg_on, input bit chk_sel, input bit rdy,
                       input bit rdy_last, input int wr_at, input int ncyc);
      bit drive;
      for (int c = 0; c < ncyc; c++) begin
         if (c == wr_at) wr_valid = 1'b1;
         step();
         drive = (c >= int'(BLANK_CYC));
         if (chk_sel) chk($sformatf("sel d%0d c%0d", s, c), sel, drive ? sel_on[s] : 6'h3F);
         chk($sformatf("seg d%0d c%0d", s, c), seg, drive ? seg_on : 8'hFF);
         chk($sformatf("frame_done d%0d c%0d", s, c), frame_done,
             (s == 5) && (c == int'(SCAN_DIV) - 1));
         chk($sformatf("wr_ready d%0d c%0d", s, c), wr_ready,
             (c == int'(SCAN_DIV) - 1) ? rdy_last : rdy);
      end
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      wr_valid = 1'b0;
      wr_data  = '0;
      wr_dp    = '0;
      wr_blank = '0;
      step();
      step();
      chk_reset("reset");
      rst = 1'b0;
      step();

      // Blank mask all ones after reset: dark display, frame_done every 60 cycles
      en = 1'b1;
      step();
      for (int k = 0; k < 20; k++) slot(k % 6, 8'hFF, 1'b0, 1'b1, 1'b1, -1, 10);
      en = 1'b0;
      step();
      step();
      chk("idle.sel", sel, 6'h3F);
      chk("idle.seg", seg, 8'hFF);

      // Write while idle commits on the next idle cycle
      wr_data  = 24'h123456;
      wr_valid = 1'b1;
      step();
      chk("idle_wr.ready_low", wr_ready, 1'b0);
      step();
      chk("idle_wr.ready_high", wr_ready, 1'b1);
      en = 1'b1;
      step();
      for (int s = 0; s < 6; s++) slot(s, seg_a[s], 1'b1, 1'b1, 1'b1, -1, 10);

      // Mid-frame write waits for frame_end; a second offer while busy is ignored
      slot(0, seg_a[0], 1'b1, 1'b1, 1'b1, -1, 10);
      slot(1, seg_a[1], 1'b1, 1'b1, 1'b1, -1, 10);
      wr_data = 24'hABCDEF;
      slot(2, seg_a[2], 1'b1, 1'b0, 1'b0, 0, 10);
      wr_data = 24'h999999;
      slot(3, seg_a[3], 1'b1, 1'b0, 1'b0, 4, 10);
      slot(4, seg_a[4], 1'b1, 1'b0, 1'b0, -1, 10);
      slot(5, seg_a[5], 1'b1, 1'b0, 1'b1, -1, 10);

      // Offer on the exact frame_end cycle: accepted, shown one frame later
      for (int s = 0; s < 5; s++) slot(s, seg_b[s], 1'b1, 1'b1, 1'b1, -1, 10);
      wr_data  = 24'h7890CB;
      wr_dp    = 6'b000100;
      wr_blank = 6'b100000;
      slot(5, seg_b[5], 1'b1, 1'b1, 1'b0, 9, 10);
      for (int s = 0; s < 5; s++) slot(s, seg_b[s], 1'b1, 1'b0, 1'b0, -1, 10);
      slot(5, seg_b[5], 1'b1, 1'b0, 1'b1, -1, 10);

      // Decimal point and blank mask
      for (int s = 0; s < 6; s++) slot(s, seg_c[s], 1'b1, 1'b1, 1'b1, -1, 10);

      // Drop enable mid-slot on digit3, then restart from digit0
      for (int s = 0; s < 3; s++) slot(s, seg_c[s], 1'b1, 1'b1, 1'b1, -1, 10);
      slot(3, seg_c[3], 1'b1, 1'b1, 1'b1, -1, 5);
      en = 1'b0;
      step();
      chk("en_drop.sel_last", sel, 6'h37);
      chk("en_drop.seg_last", seg, 8'h90);
      step();
      chk("en_drop.sel", sel, 6'h3F);
      chk("en_drop.seg", seg, 8'hFF);
      chk("en_drop.frame_done", frame_done, 1'b0);
      en = 1'b1;
      step();
      slot(0, seg_c[0], 1'b1, 1'b1, 1'b1, -1, 10);
      slot(1, seg_c[1], 1'b1, 1'b1, 1'b1, -1, 10);

      // Reset mid-DRIVE with a pending frame: shadow discarded, active cleared
      wr_data  = 24'h000000;
      wr_dp    = 6'h3F;
      wr_blank = 6'h00;
      slot(2, seg_c[2], 1'b1, 1'b0, 1'b0, 0, 6);
      rst = 1'b1;
      step();
      chk_reset("mid_rst");
      rst = 1'b0;
      step();
      slot(0, 8'hFF, 1'b0, 1'b1, 1'b1, -1, 10);
      slot(1, 8'hFF, 1'b0, 1'b1, 1'b1, -1, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
